// File: rtl/tt_briscv_pkg.sv
// Shared types and sizing for the vector load path: the per-load payload and
// the queue entry that wraps it.
package tt_briscv_pkg;

  localparam int VLEN          = 256;
  localparam int LQ_DEPTH      = 8;
  localparam int LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_wr_flag;
    logic        load;
    logic        vec_load;
    logic        vl_is_zero;
  } lq_info_s;

  typedef struct packed {
    logic            valid;
    logic            done;
    lq_info_s        info;
    logic [VLEN-1:0] data;
  } lq_entry_s;

  // Zero-length vector loads and non-loads never see a memory response.
  function automatic logic lq_done_at_alloc(lq_info_s info);
    return !(info.load | info.vec_load) | (info.vec_load & info.vl_is_zero);
  endfunction

endpackage

// File: rtl/tt_lq_ptr_ctrl.sv
// Wrap-bit read/write pointers for the load queue, with full/empty and occupancy.
module tt_lq_ptr_ctrl #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_push,
  input  logic           i_pop,
  output logic [IDX_W:0] o_wr_ptr,
  output logic [IDX_W:0] o_rd_ptr,
  output logic           o_full,
  output logic           o_empty,
  output logic [IDX_W:0] o_cnt
);

  logic [IDX_W:0] wr_ptr_reg;
  logic [IDX_W:0] rd_ptr_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (i_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (i_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign o_wr_ptr = wr_ptr_reg;
  assign o_rd_ptr = rd_ptr_reg;
  // Same slot, opposite lap: the writer is a full lap ahead of the reader.
  assign o_full   = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                    (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);
  assign o_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign o_cnt    = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/tt_vec_load_queue.sv
// In-order load queue: allocate at issue, complete out of order on memory
// response, retire to writeback in allocation order.
module tt_vec_load_queue
  import tt_briscv_pkg::*;
#(
  parameter  int LQ_DEPTH = tt_briscv_pkg::LQ_DEPTH,
  parameter  int DATA_W   = tt_briscv_pkg::VLEN,
  localparam int IDX_W    = $clog2(LQ_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alloc_vld,
  input  lq_info_s          i_alloc_info,
  output logic              o_alloc_rdy,
  output logic [IDX_W-1:0]  o_alloc_lqid,
  input  logic              i_resp_vld,
  input  logic [IDX_W-1:0]  i_resp_lqid,
  input  logic [DATA_W-1:0] i_resp_data,
  output logic              o_ret_vld,
  output lq_info_s          o_ret_info,
  output logic [DATA_W-1:0] o_ret_data,
  input  logic              i_ret_rdy,
  output logic              o_full,
  output logic              o_empty,
  output logic [IDX_W:0]    o_cnt,
  output logic              o_resp_err
);

  logic              valid_reg [LQ_DEPTH];
  logic              done_reg  [LQ_DEPTH];
  lq_info_s          info_reg  [LQ_DEPTH];
  logic [DATA_W-1:0] data_reg  [LQ_DEPTH];
  logic              resp_err_reg;

  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             alloc_fire;
  logic             ret_fire;
  logic             resp_acc;
  logic             alloc_done;

  tt_lq_ptr_ctrl #(.DEPTH(LQ_DEPTH)) u_ptr_ctrl (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_push   (alloc_fire),
    .i_pop    (ret_fire),
    .o_wr_ptr (wr_ptr),
    .o_rd_ptr (rd_ptr),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .o_cnt    (o_cnt)
  );

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // Ready looks only at registered fullness, keeping i_ret_rdy off this path.
  assign o_alloc_rdy  = !o_full;
  assign o_alloc_lqid = wr_idx;
  assign alloc_fire   = i_alloc_vld & o_alloc_rdy;
  assign alloc_done   = lq_done_at_alloc(i_alloc_info);

  assign resp_acc = i_resp_vld & valid_reg[i_resp_lqid] & !done_reg[i_resp_lqid];

  assign o_ret_vld  = valid_reg[rd_idx] & done_reg[rd_idx];
  assign o_ret_info = info_reg[rd_idx];
  assign o_ret_data = data_reg[rd_idx];
  assign ret_fire   = o_ret_vld & i_ret_rdy;

  // An allocating slot is never valid, so it cannot also be responded to or retired.
  for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_entry
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        valid_reg[gi] <= 1'b0;
        done_reg[gi]  <= 1'b0;
        info_reg[gi]  <= '0;
        data_reg[gi]  <= '0;
      end else if (alloc_fire && (wr_idx == IDX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
        done_reg[gi]  <= alloc_done;
        info_reg[gi]  <= i_alloc_info;
        data_reg[gi]  <= '0;
      end else begin
        if (resp_acc && (i_resp_lqid == IDX_W'(gi))) begin
          done_reg[gi] <= 1'b1;
          data_reg[gi] <= i_resp_data;
        end
        if (ret_fire && (rd_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
          done_reg[gi]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                     resp_err_reg <= 1'b0;
    else if (i_resp_vld && !resp_acc) resp_err_reg <= 1'b1;
  end

  assign o_resp_err = resp_err_reg;

endmodule

// File: tb/tb_tt_vec_load_queue.sv
// Bench for tt_vec_load_queue: directed scenarios plus a randomized run checked
// against an in-order queue model.
module tb_tt_vec_load_queue;
  import tt_briscv_pkg::*;

  localparam int D = 8;
  localparam int W = 256;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_alloc_vld;
  lq_info_s      i_alloc_info;
  logic          o_alloc_rdy;
  logic [2:0]    o_alloc_lqid;
  logic          i_resp_vld;
  logic [2:0]    i_resp_lqid;
  logic [W-1:0]  i_resp_data;
  logic          o_ret_vld;
  lq_info_s      o_ret_info;
  logic [W-1:0]  o_ret_data;
  logic          i_ret_rdy;
  logic          o_full;
  logic          o_empty;
  logic [3:0]    o_cnt;
  logic          o_resp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       lqid;
    bit       done;
    lq_info_s info;
    logic [W-1:0] data;
  } mentry_t;

  mentry_t q[$];
  int      alloc_cnt;
  bit      m_err;

  always #5 i_clk = ~i_clk;

  tt_vec_load_queue dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_alloc_vld  (i_alloc_vld),
    .i_alloc_info (i_alloc_info),
    .o_alloc_rdy  (o_alloc_rdy),
    .o_alloc_lqid (o_alloc_lqid),
    .i_resp_vld   (i_resp_vld),
    .i_resp_lqid  (i_resp_lqid),
    .i_resp_data  (i_resp_data),
    .o_ret_vld    (o_ret_vld),
    .o_ret_info   (o_ret_info),
    .o_ret_data   (o_ret_data),
    .i_ret_rdy    (i_ret_rdy),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_cnt        (o_cnt),
    .o_resp_err   (o_resp_err)
  );

  function automatic lq_info_s mk_info(logic [31:0] pc, bit ld, bit vld, bit vlz);
    lq_info_s r;
    r = '0;
    r.pc = pc; r.rf_wr_flag = 1'b1; r.load = ld; r.vec_load = vld; r.vl_is_zero = vlz;
    return r;
  endfunction

  task automatic idle_inputs();
    i_alloc_vld = 0; i_alloc_info = '0; i_resp_vld = 0; i_resp_lqid = '0;
    i_resp_data = '0; i_ret_rdy = 0;
  endtask

  // One clock: model applies the spec rules to the inputs present at the edge.
  task automatic tick();
    bit a_fire, r_fire;
    int idx;
    mentry_t e;
    a_fire = i_alloc_vld && (q.size() < D);
    r_fire = (q.size() > 0) && q[0].done && i_ret_rdy;
    @(posedge i_clk);
    if (i_resp_vld) begin
      idx = -1;
      foreach (q[k]) if (q[k].lqid == int'(i_resp_lqid) && !q[k].done) idx = k;
      if (idx >= 0) begin q[idx].done = 1; q[idx].data = i_resp_data; end
      else m_err = 1;
    end
    if (r_fire) void'(q.pop_front());
    if (a_fire) begin
      e.lqid = alloc_cnt % D;
      e.info = i_alloc_info;
      e.done = !(i_alloc_info.load || i_alloc_info.vec_load) ||
               (i_alloc_info.vec_load && i_alloc_info.vl_is_zero);
      e.data = '0;
      q.push_back(e);
      alloc_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1;
    q.delete(); alloc_cnt = 0; m_err = 0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset = 1;
    q.delete(); alloc_cnt = 0; m_err = 0;
    #2;
    checks++; if (o_ret_vld !== 1'b0)   begin errors++; $display("FAIL reset_ret_vld got %b want 0", o_ret_vld); end
    checks++; if (o_alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_alloc_rdy got %b want 1", o_alloc_rdy); end
    checks++; if (o_empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
    checks++; if (o_full !== 1'b0)      begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
    checks++; if (o_cnt !== 4'd0)       begin errors++; $display("FAIL reset_cnt got %0d want 0", o_cnt); end
    checks++; if (o_alloc_lqid !== 3'd0) begin errors++; $display("FAIL reset_lqid got %0d want 0", o_alloc_lqid); end
    checks++; if (o_resp_err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", o_resp_err); end
    @(posedge i_clk); #1 i_reset = 0;
    $display("test_reset done");
  endtask

  task automatic test_nonload();
    do_reset();
    checks++; if (o_alloc_lqid !== 3'd0) begin errors++; $display("FAIL nonload_lqid got %0d want 0", o_alloc_lqid); end
    i_alloc_vld = 1; i_alloc_info = mk_info(32'h100, 0, 0, 0);
    tick(); idle_inputs();
    checks++; if (o_ret_vld !== 1'b1) begin errors++; $display("FAIL nonload_ret_vld got %b want 1", o_ret_vld); end
    checks++; if (o_ret_info.pc !== 32'h100) begin errors++; $display("FAIL nonload_pc got %h want 100", o_ret_info.pc); end
    checks++; if (o_ret_data !== '0) begin errors++; $display("FAIL nonload_data got %h want 0", o_ret_data); end
    i_ret_rdy = 1; tick(); idle_inputs();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL nonload_empty_after got %b want 1", o_empty); end
    $display("test_nonload: retired pc=0x100");
  endtask

  task automatic test_out_of_order();
    logic [W-1:0] exp_d [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_alloc_vld = 1; i_alloc_info = mk_info(32'h200 + k, 1, 0, 0); tick();
    end
    idle_inputs();
    exp_d[0] = W'(32'hC); exp_d[1] = W'(32'hB); exp_d[2] = W'(32'hA);
    for (int k = 2; k >= 0; k--) begin
      checks++; if (o_ret_vld !== 1'b0) begin errors++; $display("FAIL ooo_vld_early lqid%0d got %b want 0", k, o_ret_vld); end
      i_resp_vld = 1; i_resp_lqid = 3'(k); i_resp_data = exp_d[k]; tick();
    end
    idle_inputs();
    i_ret_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ret_vld !== 1'b1 || o_ret_data !== exp_d[k] || o_ret_info.pc !== 32'h200 + k) begin
        errors++; $display("FAIL ooo_retire%0d got vld=%b data=%h pc=%h want 1 %h %h", k, o_ret_vld, o_ret_data[31:0], o_ret_info.pc, exp_d[k][31:0], 32'h200 + k);
      end
      $display("ooo retire lqid %0d data %h", k, o_ret_data[31:0]);
      tick();
    end
    idle_inputs();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ooo_empty got %b want 1", o_empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int k = 0; k < D; k++) begin
      i_alloc_vld = 1; i_alloc_info = mk_info(32'h300 + k, 0, 0, 0); tick();
    end
    checks++; if (o_full !== 1'b1 || o_alloc_rdy !== 1'b0 || o_cnt !== 4'd8) begin
      errors++; $display("FAIL full_state got full=%b rdy=%b cnt=%0d want 1 0 8", o_full, o_alloc_rdy, o_cnt); end
    i_alloc_info = mk_info(32'hDEAD, 0, 0, 0); tick();
    checks++; if (o_cnt !== 4'd8 || o_alloc_lqid !== 3'd0) begin
      errors++; $display("FAIL full_ignore got cnt=%0d lqid=%0d want 8 0", o_cnt, o_alloc_lqid); end
    idle_inputs(); i_ret_rdy = 1; tick(); idle_inputs();
    checks++; if (o_cnt !== 4'd7 || o_alloc_rdy !== 1'b1) begin
      errors++; $display("FAIL full_retire got cnt=%0d rdy=%b want 7 1", o_cnt, o_alloc_rdy); end
    checks++; if (o_alloc_lqid !== 3'd0) begin errors++; $display("FAIL wrap_lqid got %0d want 0", o_alloc_lqid); end
    i_alloc_vld = 1; i_alloc_info = mk_info(32'h400, 0, 0, 0); tick(); idle_inputs();
    checks++; if (o_cnt !== 4'd8 || o_full !== 1'b1 || o_ret_info.pc !== 32'h301) begin
      errors++; $display("FAIL wrap_refill got cnt=%0d full=%b pc=%h want 8 1 301", o_cnt, o_full, o_ret_info.pc); end
    $display("test_full_wrap done");
  endtask

  task automatic test_resp_err();
    do_reset();
    i_resp_vld = 1; i_resp_lqid = 3'd5; i_resp_data = W'(32'h55); tick(); idle_inputs();
    checks++; if (o_resp_err !== 1'b1) begin errors++; $display("FAIL resp_err_set got %b want 1", o_resp_err); end
    checks++; if (o_empty !== 1'b1 || o_cnt !== 4'd0 || o_ret_vld !== 1'b0) begin
      errors++; $display("FAIL resp_err_state got empty=%b cnt=%0d vld=%b want 1 0 0", o_empty, o_cnt, o_ret_vld); end
    repeat (3) tick();
    checks++; if (o_resp_err !== 1'b1) begin errors++; $display("FAIL resp_err_sticky got %b want 1", o_resp_err); end
    $display("test_resp_err done");
  endtask

  task automatic test_vl_zero();
    do_reset();
    i_alloc_vld = 1; i_alloc_info = mk_info(32'h500, 0, 1, 0); tick();
    i_alloc_info = mk_info(32'h504, 0, 1, 1); tick(); idle_inputs();
    checks++; if (o_ret_vld !== 1'b0) begin errors++; $display("FAIL vl_nonzero_waits got %b want 0", o_ret_vld); end
    i_resp_vld = 1; i_resp_lqid = 3'd0; i_resp_data = W'(32'h77); tick(); idle_inputs();
    i_ret_rdy = 1; tick(); idle_inputs();
    checks++; if (o_ret_vld !== 1'b1 || o_ret_info.pc !== 32'h504) begin
      errors++; $display("FAIL vl_zero got vld=%b pc=%h want 1 504", o_ret_vld, o_ret_info.pc); end
    $display("test_vl_zero done");
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_alloc_vld = 1; i_alloc_info = mk_info(32'h600 + k, 0, 0, 0); tick();
    end
    idle_inputs();
    checks++; if (o_cnt !== 4'd3 || o_ret_vld !== 1'b1) begin
      errors++; $display("FAIL mid_pre got cnt=%0d vld=%b want 3 1", o_cnt, o_ret_vld); end
    i_reset = 1; q.delete(); alloc_cnt = 0; m_err = 0;
    #1;
    checks++; if (o_ret_vld !== 1'b0 || o_empty !== 1'b1 || o_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_reset got vld=%b empty=%b cnt=%0d want 0 1 0", o_ret_vld, o_empty, o_cnt); end
    @(posedge i_clk); #1 i_reset = 0;
    checks++; if (o_alloc_lqid !== 3'd0) begin errors++; $display("FAIL mid_lqid got %0d want 0", o_alloc_lqid); end
    i_alloc_vld = 1; i_alloc_info = mk_info(32'h700, 0, 0, 0); tick(); idle_inputs();
    checks++; if (o_cnt !== 4'd1 || o_ret_info.pc !== 32'h700) begin
      errors++; $display("FAIL mid_realloc got cnt=%0d pc=%h want 1 700", o_cnt, o_ret_info.pc); end
    $display("test_reset_midstream done");
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (o_ret_vld !== ((q.size() > 0) && q[0].done) || o_cnt !== 4'(q.size()) ||
          o_full !== (q.size() == D) || o_empty !== (q.size() == 0) ||
          o_alloc_rdy !== (q.size() != D) || o_alloc_lqid !== 3'(alloc_cnt % D) || o_resp_err !== m_err) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got vld=%b cnt=%0d full=%b empty=%b rdy=%b lqid=%0d err=%b want cnt=%0d lqid=%0d err=%b",
                 cyc, o_ret_vld, o_cnt, o_full, o_empty, o_alloc_rdy, o_alloc_lqid, o_resp_err,
                 q.size(), alloc_cnt % D, m_err);
      end
      if (q.size() > 0 && q[0].done) begin
        checks++;
        if (o_ret_info !== q[0].info || o_ret_data !== q[0].data) begin
          errors++; $display("FAIL rand_head cyc %0d got pc=%h data=%h want pc=%h data=%h",
                             cyc, o_ret_info.pc, o_ret_data[31:0], q[0].info.pc, q[0].data[31:0]);
        end
      end
      i_alloc_vld  = ($urandom_range(2) != 0);
      i_alloc_info = mk_info($urandom, $urandom_range(1), $urandom_range(1), ($urandom_range(3) == 0));
      i_resp_vld   = ($urandom_range(1) != 0);
      if (q.size() > 0 && $urandom_range(15) != 0) i_resp_lqid = 3'(q[$urandom_range(q.size() - 1)].lqid);
      else i_resp_lqid = 3'($urandom_range(D - 1));
      i_resp_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      i_ret_rdy    = ($urandom_range(3) != 0);
      if (i_ret_rdy && q.size() > 0 && q[0].done)
        $display("rand cyc %0d retire lqid %0d pc %h", cyc, q[0].lqid, q[0].info.pc);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    i_reset = 1;
    test_reset();
    test_nonload();
    test_out_of_order();
    test_full_wrap();
    test_resp_err();
    test_vl_zero();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
